// File: rtl/lfsr_rand_arbiter.sv
// lfsr_rand_arbiter
//   Round-robin arbiter that hands out draws from one shared XNOR-feedback
//   LFSR. A winning requester waits STEPS cycles while the LFSR advances. It
//   then receives a one-cycle grant together with the low OUT_W LFSR bits.
//
// Ports
//   clk        system clock, rising edge
//   rst        asynchronous reset, active-high
//   seed_load  load seed into the LFSR (honoured only in IDLE)
//   seed       seed value (all-ones is replaced by 0)
//   req        per-requester request level, held until gnt
//   gnt        one-hot grant pulse, one cycle
//   rnd_valid  high together with gnt
//   rnd_out    random value while rnd_valid, 0 otherwise
//   busy       high in STEP and GRANT
//
// Optional build macro
//   LFSR_FREE_RUN_EN  when defined, the LFSR also advances on every IDLE cycle
//                     that is not a seed-load cycle.
//
// State table
//   S_IDLE  | wait for requests, accept seed loads
//   S_STEP  | advance LFSR once per cycle, STEPS times, for the latched winner
//   S_GRANT | one-cycle grant pulse, advance round-robin pointer
module lfsr_rand_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int LFSR_W  = 5,
  parameter int OUT_W   = 2,
  parameter int STEPS   = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               seed_load,
  input  logic [LFSR_W-1:0]  seed,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] gnt,
  output logic               rnd_valid,
  output logic [OUT_W-1:0]   rnd_out,
  output logic               busy
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = (STEPS > 1) ? $clog2(STEPS + 1) : 1;

  // Tap masks for the supported widths, laid out on an 8-bit field.
  localparam logic [7:0] TAP8 = (LFSR_W == 5) ? 8'b0001_0100 :
                                (LFSR_W == 6) ? 8'b0011_0000 :
                                (LFSR_W == 7) ? 8'b0110_0000 :
                                                8'b1011_1000;
  localparam logic [LFSR_W-1:0] TAP_MASK = TAP8[LFSR_W-1:0];

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_STEP  = 2'd1,
    S_GRANT = 2'd2
  } state_t;

  state_t             state, state_nxt;
  logic [LFSR_W-1:0]  lfsr, lfsr_nxt, lfsr_shift;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic [IDX_W-1:0]   win, win_nxt;
  logic [IDX_W-1:0]   rr_ptr, rr_ptr_nxt;
  logic [NUM_REQ-1:0] gnt_nxt;
  logic               rnd_valid_nxt;
  logic [OUT_W-1:0]   rnd_out_nxt;
  logic               busy_nxt;

  logic               found;
  logic [IDX_W-1:0]   sel_idx;
  int                 idx;

  // XNOR feedback: all-zero is a legal state, all-ones is the lockup state.
  assign lfsr_shift = {lfsr[LFSR_W-2:0], ~(^(lfsr & TAP_MASK))};

  // First requester at or above rr_ptr, wrapping modulo NUM_REQ.
  always_comb begin
    found   = 1'b0;
    sel_idx = '0;
    idx     = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = int'(rr_ptr) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!found && req[idx]) begin
        found   = 1'b1;
        sel_idx = IDX_W'(idx);
      end
    end
  end

  always_comb begin
    state_nxt     = state;
    lfsr_nxt      = lfsr;
    cnt_nxt       = cnt;
    win_nxt       = win;
    rr_ptr_nxt    = rr_ptr;
    gnt_nxt       = '0;
    rnd_valid_nxt = 1'b0;
    rnd_out_nxt   = '0;

    case (state)
      S_IDLE: begin
        if (seed_load) begin
          // Seed load wins over arbitration; req is looked at again next cycle.
          lfsr_nxt = (&seed) ? '0 : seed;
        end else begin
`ifdef LFSR_FREE_RUN_EN
          lfsr_nxt = lfsr_shift;
`endif
          if (found) begin
            win_nxt   = sel_idx;
            cnt_nxt   = CNT_W'(STEPS);
            state_nxt = S_STEP;
          end
        end
      end

      S_STEP: begin
        lfsr_nxt = lfsr_shift;
        cnt_nxt  = cnt - CNT_W'(1);
        if (!req[win]) begin
          // Requester withdrew: complete this shift and drop the draw.
          cnt_nxt   = '0;
          state_nxt = S_IDLE;
        end else if (cnt == CNT_W'(1)) begin
          state_nxt     = S_GRANT;
          gnt_nxt[win]  = 1'b1;
          rnd_valid_nxt = 1'b1;
          rnd_out_nxt   = lfsr_shift[OUT_W-1:0];
        end
      end

      S_GRANT: begin
        rr_ptr_nxt = (win == IDX_W'(NUM_REQ - 1)) ? '0 : win + IDX_W'(1);
        state_nxt  = S_IDLE;
      end

      default: state_nxt = S_IDLE;
    endcase

    busy_nxt = (state_nxt != S_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      lfsr      <= '0;
      cnt       <= '0;
      win       <= '0;
      rr_ptr    <= '0;
      gnt       <= '0;
      rnd_valid <= 1'b0;
      rnd_out   <= '0;
      busy      <= 1'b0;
    end else begin
      state     <= state_nxt;
      lfsr      <= lfsr_nxt;
      cnt       <= cnt_nxt;
      win       <= win_nxt;
      rr_ptr    <= rr_ptr_nxt;
      gnt       <= gnt_nxt;
      rnd_valid <= rnd_valid_nxt;
      rnd_out   <= rnd_out_nxt;
      busy      <= busy_nxt;
    end
  end

endmodule

// File: tb/tb_lfsr_rand_arbiter.sv
module tb_lfsr_rand_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       seed_load;
  logic [4:0] seed;
  logic [3:0] req;
  logic [3:0] gnt;
  logic       rnd_valid;
  logic [1:0] rnd_out;
  logic       busy;

  int checks = 0;
  int errors = 0;

  lfsr_rand_arbiter #(
    .NUM_REQ(4), .LFSR_W(5), .OUT_W(2), .STEPS(5)
  ) dut (
    .clk(clk), .rst(rst), .seed_load(seed_load), .seed(seed), .req(req),
    .gnt(gnt), .rnd_valid(rnd_valid), .rnd_out(rnd_out), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle_outs(input string tag);
    check({tag, "_gnt"}, 32'(gnt), 32'h0);
    check({tag, "_vld"}, 32'(rnd_valid), 32'h0);
    check({tag, "_rnd"}, 32'(rnd_out), 32'h0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #12;
    rst = 1'b0;
    #1;
  endtask

  initial begin
    rst = 1'b1; seed_load = 1'b0; seed = '0; req = '0;
    @(posedge clk); #1;

    // Reset state
    check_idle_outs("rst");
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_lfsr", 32'(dut.lfsr), 32'h0);
    check("rst_rr", 32'(dut.rr_ptr), 32'h0);
    rst = 1'b0;
    #1;

    // First draw: req[0] from cycle 0, gnt at cycle 6
    req = 4'b0001;
    tick(1);
    check("s1_busy_c1", 32'(busy), 32'h1);
    check("s1_gnt_c1", 32'(gnt), 32'h0);
    tick(4);
    check("s1_gnt_c5", 32'(gnt), 32'h0);
    tick(1);
    check("s1_gnt", 32'(gnt), 32'h1);
    check("s1_vld", 32'(rnd_valid), 32'h1);
    check("s1_lfsr", 32'(dut.lfsr), 32'h1C);
    check("s1_rnd", 32'(rnd_out), 32'h0);
    check("s1_busy", 32'(busy), 32'h1);
    tick(1);
    check_idle_outs("s1_c7");
    check("s1_c7_busy", 32'(busy), 32'h0);
    check("s1_rr", 32'(dut.rr_ptr), 32'h1);

    // Second draw: req[0] still high, gnt at cycle 13
    tick(5);
    check("s2_gnt_c12", 32'(gnt), 32'h0);
    tick(1);
    check("s2_gnt", 32'(gnt), 32'h1);
    check("s2_lfsr", 32'(dut.lfsr), 32'h11);
    check("s2_rnd", 32'(rnd_out), 32'h1);
    req = 4'b0000;
    tick(1);
    check("s2_busy_after", 32'(busy), 32'h0);

    // Seed 0x01 with a same-cycle request: seed load wins, then req[2]
    seed_load = 1'b1; seed = 5'h01; req = 4'b0100;
    tick(1);
    check("s3_seed_lfsr", 32'(dut.lfsr), 32'h01);
    check("s3_seed_busy", 32'(busy), 32'h0);
    seed_load = 1'b0;
    tick(6);
    check("s3_gnt", 32'(gnt), 32'h4);
    check("s3_lfsr", 32'(dut.lfsr), 32'h19);
    check("s3_rnd", 32'(rnd_out), 32'h1);
    req = 4'b0000;
    tick(1);
    check("s3_rr", 32'(dut.rr_ptr), 32'h3);

    // Seed 0x1F loads 0; draw reproduces the first scenario
    seed_load = 1'b1; seed = 5'h1F;
    tick(1);
    check("s4_seed_lfsr", 32'(dut.lfsr), 32'h0);
    seed_load = 1'b0; req = 4'b0001;
    tick(6);
    check("s4_gnt", 32'(gnt), 32'h1);
    check("s4_lfsr", 32'(dut.lfsr), 32'h1C);
    check("s4_rnd", 32'(rnd_out), 32'h0);
    req = 4'b0000;
    tick(1);

    // All requesters continuously from reset: order 0,1,2,3,0 every 7 cycles
    do_reset();
    req = 4'b1111;
    for (int t = 1; t <= 34; t++) begin
      logic [3:0] exp_g;
      tick(1);
      exp_g = 4'b0000;
      if (t % 7 == 6) exp_g = 4'b0001 << ((t / 7) % 4);
      check($sformatf("rr_gnt_t%0d", t), 32'(gnt), 32'(exp_g));
      check($sformatf("rr_onehot_t%0d", t), 32'($onehot0(gnt)), 32'h1);
    end
    req = 4'b0000;
    tick(1);

    // req[1] withdrawn during STEP at cycle 3: no grant, rr_ptr unchanged
    do_reset();
    req = 4'b0010;
    tick(3);
    check("ab_busy_c3", 32'(busy), 32'h1);
    req = 4'b0000;
    tick(1);
    check_idle_outs("ab_c4");
    check("ab_busy_c4", 32'(busy), 32'h0);
    check("ab_rr", 32'(dut.rr_ptr), 32'h0);
    check("ab_lfsr", 32'(dut.lfsr), 32'h07);
    tick(3);
    check("ab_no_gnt", 32'(gnt), 32'h0);
    req = 4'b0011;
    tick(6);
    check("ab_next_gnt", 32'(gnt), 32'h1);
    check("ab_next_lfsr", 32'(dut.lfsr), 32'h04);
    check("ab_next_rnd", 32'(rnd_out), 32'h0);
    req = 4'b0000;
    tick(1);

    // Reset pulsed mid-STEP: outputs clear asynchronously, sequence restarts
    do_reset();
    req = 4'b0001;
    tick(3);
    check("rs_busy_pre", 32'(busy), 32'h1);
    rst = 1'b1;
    #1;
    check("rs_busy_async", 32'(busy), 32'h0);
    check("rs_gnt_async", 32'(gnt), 32'h0);
    check("rs_vld_async", 32'(rnd_valid), 32'h0);
    check("rs_lfsr_async", 32'(dut.lfsr), 32'h0);
    #3;
    rst = 1'b0;
    #1;
    tick(6);
    check("rs_gnt", 32'(gnt), 32'h1);
    check("rs_lfsr", 32'(dut.lfsr), 32'h1C);
    check("rs_rnd", 32'(rnd_out), 32'h0);
    req = 4'b0000;
    tick(1);
    check_idle_outs("rs_end");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lfsr_rand_arbiter.md
Name: lfsr_rand_arbiter

Overview:
- Shares one XNOR-feedback LFSR random source between NUM_REQ requesters in the VGA subsystem (sprite/placement logic, for example).
- Arbitrates requests round-robin.
- Advances the LFSR a fixed number of steps between draws, so consecutive draws are not shifted copies of each other.
- Returns an OUT_W-bit random value with a one-cycle grant pulse.
- Supports seed loading while idle.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- LFSR_W, 5, LFSR width; supported values are 5, 6, 7, 8.
- OUT_W, 2, width of the returned random value (1..LFSR_W).
- STEPS, 5, LFSR shifts performed between arbitration and grant (>=1).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- seed_load  in  1  load seed into the LFSR (honoured only in IDLE).
- seed  in  LFSR_W  seed value.
- req  in  NUM_REQ  per-requester request level; held until gnt.
- gnt  out  NUM_REQ  one-hot grant pulse, one cycle.
- rnd_valid  out  1  high in the same cycle as gnt.
- rnd_out  out  OUT_W  random value; valid only while rnd_valid is high, 0 otherwise.
- busy  out  1  high in the STEP and GRANT states.

Behaviour:
- Reset (async, active-high):
  - lfsr=0, state=IDLE, rr_ptr=0, step counter=0.
  - gnt=0, rnd_valid=0, rnd_out=0, busy=0.
- LFSR shift: lfsr <= {lfsr[LFSR_W-2:0], fb}, where fb is the XNOR of the tap bits:
  - W=5: bits 4,2.
  - W=6: bits 5,4.
  - W=7: bits 6,5.
  - W=8: bits 7,5,4,3.
  - All-ones is the XNOR lockup state and must never be held.
- Seed load: seed_load=1 in IDLE with no winner selected that cycle loads seed, except seed == all-ones, which loads 0.
  - seed_load has priority over a new arbitration in the same cycle; req is re-evaluated next cycle.
  - seed_load is ignored outside IDLE.
- IDLE:
  - If any req bit is high, select the winner round-robin: the first set bit at or above rr_ptr, wrapping modulo NUM_REQ.
  - Latch the winner index, load the step counter with STEPS, go to STEP.
- STEP:
  - Shift the LFSR once per cycle and decrement the counter; go to GRANT after STEPS shifts.
  - If the latched winner's req drops during STEP, finish the current shift, then go to IDLE with no grant; rr_ptr is unchanged.
- GRANT (exactly one cycle):
  - gnt[winner]=1, rnd_valid=1, rnd_out=lfsr[OUT_W-1:0]. The LFSR does not shift.
  - rr_ptr <= (winner+1) mod NUM_REQ. Next state is IDLE.
- Latency: with req asserted in IDLE at cycle 0, gnt occurs at cycle STEPS+1. Back-to-back grants are STEPS+2 cycles apart.
- Requesters must drop req in the cycle after gnt. A req still high then is treated as a new request.
- Outputs are registered; all outputs are 0 outside GRANT except busy.
- Asserting rst mid-STEP or mid-GRANT aborts immediately to reset values; no partial grant is issued.

Optional Feature:
- Macro: LFSR_FREE_RUN_EN.
- Defined: the LFSR also shifts every IDLE cycle (except a seed_load cycle), so draw values depend on request timing.
- Undefined: the LFSR shifts only in STEP, and draw sequences are fully deterministic from seed.
- The Test Plan values assume the macro is undefined.

Test Plan:
- Reset, then req=4'b0001 held from cycle 0 → gnt=4'b0001 at cycle 6, rnd_valid=1, lfsr=5'h1C, rnd_out=2'b00; all outputs 0 at cycle 7.
- Keep req[0] high after the first grant → second gnt=4'b0001 at cycle 13, lfsr=5'h11, rnd_out=2'b01.
- seed_load=1 with seed=5'h01 in IDLE, then req[2] → gnt=4'b0100, lfsr=5'h19, rnd_out=2'b01. Repeat with seed=5'h1F → lfsr loads 0, same result as the first scenario.
- req=4'b1111 held continuously from reset → grant order 0,1,2,3,0, each grant 7 cycles apart; gnt is always one-hot.
- req[1] raised and then dropped during STEP at cycle 3 → no gnt, state returns to IDLE, rr_ptr stays 0; next req=4'b0011 grants index 0.
- rst pulsed during the STEP state → gnt, rnd_valid and busy are 0 immediately (asynchronously); after release the sequence restarts from lfsr=0.
